// File: rtl/snoop_responder.sv
// Snoop responder: looks up the local tag/MESI array for a bus snoop, updates MESI,
// pushes a writeback on HITM and returns NOHIT/HIT/HITM. SNOOP_STATS_EN adds result counters.
module snoop_responder #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  parameter int WAY_W    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          snoop_valid,
  output logic                          snoop_ready,
  input  logic [2:0]                    snoop_op,
  input  logic [ADDR_W-1:0]             snoop_addr,
  output logic                          lkp_req,
  output logic [INDEX_W-1:0]            lkp_index,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] lkp_tag,
  input  logic                          lkp_hit,
  input  logic [WAY_W-1:0]              lkp_way,
  input  logic [1:0]                    lkp_mesi,
  output logic                          upd_en,
  output logic [WAY_W-1:0]              upd_way,
  output logic [1:0]                    upd_mesi,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [ADDR_W-1:0]             wb_addr,
  output logic [WAY_W-1:0]              wb_way,
  output logic                          resp_valid,
  output logic [1:0]                    snoop_result,
  output logic                          proto_err
`ifdef SNOOP_STATS_EN
  ,
  input  logic                          clr_stats,
  output logic [15:0]                   cnt_hit,
  output logic [15:0]                   cnt_hitm,
  output logic [15:0]                   cnt_nohit
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_M = 2'd3;

  typedef enum logic [2:0] {IDLE, REQ, EVAL, WB, RESP} state_t;
  typedef enum logic [1:0] {RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2} result_t;

  state_t              state, next_state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  result_t             res_q;
  logic [WAY_W-1:0]    wb_way_q;

  logic [1:0]          mesi_eff;
  logic [1:0]          dec_mesi;
  result_t             dec_result;
  logic                dec_err;
  logic                state_change;
  logic                unused_offset;

  // The offset bits of the latched address never reach any output.
  assign unused_offset = ^addr_q[OFFSET_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      res_q    <= RES_NOHIT;
      wb_way_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && snoop_valid) begin
        op_q   <= snoop_op;
        addr_q <= snoop_addr;
      end
      if (state == EVAL) begin
        res_q    <= dec_result;
        wb_way_q <= lkp_way;
      end
    end
  end

  // Decision table; a lookup miss behaves exactly like a line in I.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mesi_eff   = lkp_hit ? lkp_mesi : MESI_I;
    dec_mesi   = mesi_eff;
    dec_result = RES_NOHIT;
    dec_err    = 1'b0;
    case (op_q)
      OP_READ: begin
        if (mesi_eff == MESI_M) begin
          dec_result = RES_HITM;
          dec_mesi   = MESI_S;
        end else if (mesi_eff != MESI_I) begin
          dec_result = RES_HIT;
          dec_mesi   = MESI_S;
        end
      end
      OP_RWIM: begin
        if (mesi_eff == MESI_M) begin
          dec_result = RES_HITM;
          dec_mesi   = MESI_I;
        end else if (mesi_eff != MESI_I) begin
          dec_result = RES_HIT;
          dec_mesi   = MESI_I;
        end
      end
      OP_INV: begin
        if (mesi_eff == MESI_S) begin
          dec_result = RES_HIT;
          dec_mesi   = MESI_I;
        end else if (mesi_eff != MESI_I) begin
          dec_err = 1'b1;
        end
      end
      OP_WRITE: ;
      default: dec_err = 1'b1;
    endcase
    state_change = (dec_mesi != mesi_eff);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (snoop_valid) next_state = REQ;
      REQ:  next_state = EVAL;
      EVAL: next_state = (dec_result == RES_HITM) ? WB : RESP;
      WB:   if (wb_ready) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign lkp_index = addr_q[OFFSET_W +: INDEX_W];
  assign lkp_tag   = addr_q[ADDR_W-1 -: TAG_W];

  always_comb begin
    snoop_ready  = 1'b0;
    lkp_req      = 1'b0;
    upd_en       = 1'b0;
    upd_way      = '0;
    upd_mesi     = '0;
    wb_valid     = 1'b0;
    wb_addr      = '0;
    wb_way       = '0;
    resp_valid   = 1'b0;
    snoop_result = RES_NOHIT;
    proto_err    = 1'b0;
    case (state)
      IDLE: snoop_ready = 1'b1;
      REQ:  lkp_req = 1'b1;
      EVAL: begin
        upd_en    = state_change;
        upd_way   = state_change ? lkp_way : '0;
        upd_mesi  = state_change ? dec_mesi : '0;
        proto_err = dec_err;
      end
      WB: begin
        wb_valid = 1'b1;
        wb_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        wb_way   = wb_way_q;
      end
      RESP: begin
        resp_valid   = 1'b1;
        snoop_result = res_q;
      end
      default: ;
    endcase
  end

`ifdef SNOOP_STATS_EN
  // Saturating result counters; a clear in the same cycle beats an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_hit   <= '0;
      cnt_hitm  <= '0;
      cnt_nohit <= '0;
    end else if (clr_stats) begin
      cnt_hit   <= '0;
      cnt_hitm  <= '0;
      cnt_nohit <= '0;
    end else if (state == RESP) begin
      if (res_q == RES_HIT && cnt_hit != 16'hFFFF)     cnt_hit   <= cnt_hit + 16'd1;
      if (res_q == RES_HITM && cnt_hitm != 16'hFFFF)   cnt_hitm  <= cnt_hitm + 16'd1;
      if (res_q == RES_NOHIT && cnt_nohit != 16'hFFFF) cnt_nohit <= cnt_nohit + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Directed self-checking bench for snoop_responder; define SNOOP_STATS_EN to also cover the counters.
module tb_snoop_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snoop_valid = 1'b0;
  logic        snoop_ready;
  logic [2:0]  snoop_op = '0;
  logic [31:0] snoop_addr = '0;
  logic        lkp_req;
  logic [13:0] lkp_index;
  logic [11:0] lkp_tag;
  logic        lkp_hit = 1'b0;
  logic [2:0]  lkp_way = '0;
  logic [1:0]  lkp_mesi = '0;
  logic        upd_en;
  logic [2:0]  upd_way;
  logic [1:0]  upd_mesi;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_addr;
  logic [2:0]  wb_way;
  logic        resp_valid;
  logic [1:0]  snoop_result;
  logic        proto_err;
`ifdef SNOOP_STATS_EN
  logic        clr_stats = 1'b0;
  logic [15:0] cnt_hit, cnt_hitm, cnt_nohit;
`endif

  int checks = 0;
  int errors = 0;

  // Observations of the most recent snoop
  logic        o_ready_before, o_lkp_req, o_ready_after, o_resp_after;
  logic [13:0] o_index;
  logic [11:0] o_tag;
  int          o_upd_n, o_upd_cyc, o_perr_n, o_wb_n, o_resp_cyc, o_busy_ready_n;
  logic [2:0]  o_upd_way, o_wb_way;
  logic [1:0]  o_upd_mesi, o_result;
  logic [31:0] o_wb_addr;

  snoop_responder dut (
    .clk(clk), .rst(rst),
    .snoop_valid(snoop_valid), .snoop_ready(snoop_ready), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .lkp_req(lkp_req), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
    .lkp_hit(lkp_hit), .lkp_way(lkp_way), .lkp_mesi(lkp_mesi),
    .upd_en(upd_en), .upd_way(upd_way), .upd_mesi(upd_mesi),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_way(wb_way),
    .resp_valid(resp_valid), .snoop_result(snoop_result), .proto_err(proto_err)
`ifdef SNOOP_STATS_EN
    , .clr_stats(clr_stats), .cnt_hit(cnt_hit), .cnt_hitm(cnt_hitm), .cnt_nohit(cnt_nohit)
`endif
  );

  always #5 clk = ~clk;

  // Issues one snoop from an IDLE negedge and records what the DUT does until the cycle after RESP.
  // Cycle c counts negedges after the accept edge; wb_ready rises wb_delay cycles after wb_valid first shows.
  task automatic do_snoop(input logic [2:0] op, input logic [31:0] addr, input logic hit,
                          input logic [2:0] way, input logic [1:0] mesi, input int wb_delay,
                          input logic hold_valid);
    int wb_cnt;
    o_ready_before = snoop_ready;
    snoop_valid = 1'b1; snoop_op = op; snoop_addr = addr;
    @(negedge clk);
    snoop_valid = hold_valid;
    lkp_hit = hit; lkp_way = way; lkp_mesi = mesi;
    o_upd_n = 0; o_upd_cyc = -1; o_perr_n = 0; o_wb_n = 0; o_resp_cyc = -1; o_busy_ready_n = 0;
    o_upd_way = '0; o_upd_mesi = '0; o_wb_addr = '0; o_wb_way = '0; o_result = '0;
    o_lkp_req = lkp_req; o_index = lkp_index; o_tag = lkp_tag;
    wb_cnt = 0;
    for (int c = 1; c <= 40 && o_resp_cyc < 0; c++) begin
      if (snoop_ready) o_busy_ready_n++;
      if (upd_en) begin o_upd_n++; o_upd_cyc = c; o_upd_way = upd_way; o_upd_mesi = upd_mesi; end
      if (proto_err) o_perr_n++;
      if (wb_valid) begin
        o_wb_n++; o_wb_addr = wb_addr; o_wb_way = wb_way;
        if (wb_cnt == wb_delay) wb_ready = 1'b1;
        wb_cnt++;
      end
      if (resp_valid) begin o_resp_cyc = c; o_result = snoop_result; end
      @(negedge clk);
    end
    wb_ready = 1'b0;
    lkp_hit = 1'b0; lkp_way = '0; lkp_mesi = '0;
    o_ready_after = snoop_ready;
    o_resp_after  = resp_valid;
  endtask

  task automatic test_reset;
    checks++; if (snoop_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h exp 1", snoop_ready); end
    checks++; if ({lkp_req, upd_en, wb_valid, resp_valid, proto_err} !== 5'b0) begin errors++;
      $display("FAIL rst_strobes got %05b exp 00000", {lkp_req, upd_en, wb_valid, resp_valid, proto_err}); end
    checks++; if ({lkp_index, lkp_tag, wb_addr, snoop_result} !== 60'd0) begin errors++;
      $display("FAIL rst_data got idx %0h tag %0h wba %0h res %0h exp all 0", lkp_index, lkp_tag, wb_addr, snoop_result); end
  endtask

  task automatic test_read_modified;
    do_snoop(3'd1, 32'h1234_5678, 1'b1, 3'd2, 2'd3, 2, 1'b0);
    checks++; if (o_lkp_req !== 1'b1) begin errors++; $display("FAIL rdm_lkp_req got %0h exp 1", o_lkp_req); end
    checks++; if (o_index !== 14'h1159) begin errors++; $display("FAIL rdm_index got %0h exp 1159", o_index); end
    checks++; if (o_tag !== 12'h123) begin errors++; $display("FAIL rdm_tag got %0h exp 123", o_tag); end
    checks++; if (o_upd_n !== 1 || o_upd_cyc !== 2 || o_upd_mesi !== 2'd1 || o_upd_way !== 3'd2) begin errors++;
      $display("FAIL rdm_upd got n %0d cyc %0d mesi %0h way %0h exp 1 2 1 2", o_upd_n, o_upd_cyc, o_upd_mesi, o_upd_way); end
    checks++; if (o_wb_n !== 3 || o_wb_addr !== 32'h1234_5640 || o_wb_way !== 3'd2) begin errors++;
      $display("FAIL rdm_wb got n %0d addr %0h way %0h exp 3 12345640 2", o_wb_n, o_wb_addr, o_wb_way); end
    checks++; if (o_resp_cyc !== 6 || o_result !== 2'd2) begin errors++;
      $display("FAIL rdm_resp got cyc %0d res %0h exp 6 2", o_resp_cyc, o_result); end
    checks++; if (o_ready_after !== 1'b1 || o_resp_after !== 1'b0 || o_busy_ready_n !== 0) begin errors++;
      $display("FAIL rdm_after got ready %0h resp %0h busy_ready %0d exp 1 0 0", o_ready_after, o_resp_after, o_busy_ready_n); end
  endtask

  task automatic test_rwim_shared;
    do_snoop(3'd4, 32'h0000_2080, 1'b1, 3'd4, 2'd1, 0, 1'b0);
    checks++; if (o_resp_cyc !== 3 || o_result !== 2'd1) begin errors++;
      $display("FAIL rwim_resp got cyc %0d res %0h exp 3 1", o_resp_cyc, o_result); end
    checks++; if (o_upd_n !== 1 || o_upd_mesi !== 2'd0 || o_upd_way !== 3'd4) begin errors++;
      $display("FAIL rwim_upd got n %0d mesi %0h way %0h exp 1 0 4", o_upd_n, o_upd_mesi, o_upd_way); end
    checks++; if (o_wb_n !== 0 || o_perr_n !== 0) begin errors++;
      $display("FAIL rwim_nowb got wb %0d perr %0d exp 0 0", o_wb_n, o_perr_n); end
  endtask

  task automatic test_invalidate;
    do_snoop(3'd3, 32'h0000_30C0, 1'b1, 3'd1, 2'd2, 0, 1'b0);
    checks++; if (o_perr_n !== 1 || o_result !== 2'd0 || o_upd_n !== 0 || o_resp_cyc !== 3) begin errors++;
      $display("FAIL inv_e got perr %0d res %0h upd %0d cyc %0d exp 1 0 0 3", o_perr_n, o_result, o_upd_n, o_resp_cyc); end
    do_snoop(3'd3, 32'h0000_30C0, 1'b1, 3'd6, 2'd1, 0, 1'b0);
    checks++; if (o_result !== 2'd1 || o_upd_n !== 1 || o_upd_mesi !== 2'd0 || o_upd_way !== 3'd6 || o_perr_n !== 0) begin
      errors++; $display("FAIL inv_s got res %0h upd %0d mesi %0h way %0h perr %0d exp 1 1 0 6 0",
                         o_result, o_upd_n, o_upd_mesi, o_upd_way, o_perr_n); end
  endtask

  task automatic test_write_miss;
    do_snoop(3'd2, 32'h0000_4000, 1'b1, 3'd3, 2'd3, 0, 1'b0);
    checks++; if (o_result !== 2'd0 || o_upd_n !== 0 || o_wb_n !== 0 || o_perr_n !== 0 || o_resp_cyc !== 3) begin errors++;
      $display("FAIL write_m got res %0h upd %0d wb %0d perr %0d cyc %0d exp 0 0 0 0 3",
               o_result, o_upd_n, o_wb_n, o_perr_n, o_resp_cyc); end
    do_snoop(3'd1, 32'h0000_4000, 1'b0, 3'd3, 2'd3, 0, 1'b0);
    checks++; if (o_result !== 2'd0 || o_upd_n !== 0 || o_wb_n !== 0) begin errors++;
      $display("FAIL read_miss got res %0h upd %0d wb %0d exp 0 0 0", o_result, o_upd_n, o_wb_n); end
    // Already shared: HIT but no MESI write
    do_snoop(3'd1, 32'h0000_4000, 1'b1, 3'd0, 2'd1, 0, 1'b0);
    checks++; if (o_result !== 2'd1 || o_upd_n !== 0) begin errors++;
      $display("FAIL read_s got res %0h upd %0d exp 1 0", o_result, o_upd_n); end
    do_snoop(3'd6, 32'h0000_4000, 1'b1, 3'd0, 2'd1, 0, 1'b0);
    checks++; if (o_result !== 2'd0 || o_upd_n !== 0 || o_perr_n !== 1) begin errors++;
      $display("FAIL bad_op got res %0h upd %0d perr %0d exp 0 0 1", o_result, o_upd_n, o_perr_n); end
  endtask

  task automatic test_reset_mid_wb;
    int bad;
    snoop_valid = 1'b1; snoop_op = 3'd1; snoop_addr = 32'h0000_1040;
    @(negedge clk);
    snoop_valid = 1'b0; lkp_hit = 1'b1; lkp_way = 3'd5; lkp_mesi = 2'd3;
    @(negedge clk);
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 32'h0000_1040 || wb_way !== 3'd5) begin errors++;
      $display("FAIL rwb_inwb got v %0h addr %0h way %0h exp 1 1040 5", wb_valid, wb_addr, wb_way); end
    rst = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b0 || snoop_ready !== 1'b1) begin errors++;
      $display("FAIL rwb_async got wb %0h ready %0h exp 0 1", wb_valid, snoop_ready); end
    @(negedge clk);
    rst = 1'b0; lkp_hit = 1'b0; lkp_way = '0; lkp_mesi = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid || upd_en || wb_valid || !snoop_ready) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rwb_quiet got %0d bad cycles exp 0", bad); end
    do_snoop(3'd1, 32'h0000_1040, 1'b1, 3'd5, 2'd2, 0, 1'b0);
    checks++; if (o_result !== 2'd1 || o_resp_cyc !== 3 || o_upd_n !== 1 || o_upd_mesi !== 2'd1 || o_index !== 14'h41) begin
      errors++; $display("FAIL rwb_retry got res %0h cyc %0d upd %0d mesi %0h idx %0h exp 1 3 1 1 41",
                         o_result, o_resp_cyc, o_upd_n, o_upd_mesi, o_index); end
  endtask

  task automatic test_back_to_back;
    // snoop_valid stays high while busy; the second snoop is taken on the first IDLE edge.
    do_snoop(3'd4, 32'h0000_5000, 1'b1, 3'd7, 2'd2, 0, 1'b1);
    checks++; if (o_busy_ready_n !== 0 || o_resp_cyc !== 3 || o_result !== 2'd1 || o_ready_after !== 1'b1) begin errors++;
      $display("FAIL b2b_first got busy_ready %0d cyc %0d res %0h ready %0h exp 0 3 1 1",
               o_busy_ready_n, o_resp_cyc, o_result, o_ready_after); end
    do_snoop(3'd1, 32'h0010_0240, 1'b1, 3'd1, 2'd3, 0, 1'b0);
    checks++; if (o_index !== 14'h9 || o_tag !== 12'h001 || o_result !== 2'd2 || o_resp_cyc !== 4) begin errors++;
      $display("FAIL b2b_second got idx %0h tag %0h res %0h cyc %0d exp 9 1 2 4", o_index, o_tag, o_result, o_resp_cyc); end
  endtask

`ifdef SNOOP_STATS_EN
  task automatic test_stats;
    clr_stats = 1'b1; @(negedge clk); clr_stats = 1'b0;
    do_snoop(3'd1, 32'h100, 1'b1, 3'd0, 2'd2, 0, 1'b0);
    do_snoop(3'd4, 32'h140, 1'b1, 3'd0, 2'd1, 0, 1'b0);
    do_snoop(3'd3, 32'h180, 1'b1, 3'd0, 2'd1, 0, 1'b0);
    do_snoop(3'd1, 32'h1C0, 1'b1, 3'd0, 2'd3, 1, 1'b0);
    do_snoop(3'd2, 32'h200, 1'b1, 3'd0, 2'd3, 0, 1'b0);
    do_snoop(3'd1, 32'h240, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    checks++; if (cnt_hit !== 16'd3 || cnt_hitm !== 16'd1 || cnt_nohit !== 16'd2) begin errors++;
      $display("FAIL stats_cnt got %0d/%0d/%0d exp 3/1/2", cnt_hit, cnt_hitm, cnt_nohit); end
    clr_stats = 1'b1; @(negedge clk); clr_stats = 1'b0;
    checks++; if (cnt_hit !== 16'd0 || cnt_hitm !== 16'd0 || cnt_nohit !== 16'd0) begin errors++;
      $display("FAIL stats_clr got %0d/%0d/%0d exp 0/0/0", cnt_hit, cnt_hitm, cnt_nohit); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_read_modified;
    test_rwim_shared;
    test_invalidate;
    test_write_miss;
    test_reset_mid_wb;
    test_back_to_back;
`ifdef SNOOP_STATS_EN
    test_stats;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Answers bus snoops issued by other caches. Looks up the local tag/MESI array, returns HIT, HITM or NOHIT, and updates the local MESI state.
- On HITM, pushes a writeback of the modified line before presenting the result.
- Sits between the shared-bus snoop interface and the L1 tag array. It is the producing end of the snoop result that the requesting cache consumes.

Parameters:
ADDR_W, 32, physical address width
OFFSET_W, 6, line offset bits (64-byte line)
INDEX_W, 14, set index bits
WAY_W, 3, way select width (8 ways)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
snoop_valid  input  1  snoop request present
snoop_ready  output  1  responder idle, can accept
snoop_op  input  3  bus op: READ=1, WRITE=2, INVALIDATE=3, RWIM=4
snoop_addr  input  ADDR_W  snooped address
lkp_req  output  1  tag lookup strobe
lkp_index  output  INDEX_W  lookup set
lkp_tag  output  ADDR_W-INDEX_W-OFFSET_W  lookup tag
lkp_hit  input  1  lookup hit; valid the cycle after lkp_req
lkp_way  input  WAY_W  hitting way
lkp_mesi  input  2  line state: I=0, S=1, E=2, M=3
upd_en  output  1  MESI write strobe
upd_way  output  WAY_W  way to write
upd_mesi  output  2  new MESI state
wb_valid  output  1  writeback request
wb_ready  input  1  writeback accepted
wb_addr  output  ADDR_W  line-aligned address, offset bits zero
wb_way  output  WAY_W  way holding dirty data
resp_valid  output  1  result valid, one-cycle pulse
snoop_result  output  2  NOHIT=0, HIT=1, HITM=2
proto_err  output  1  one-cycle pulse on illegal state/op combination

Behaviour:
- Reset: state IDLE. All outputs 0 except snoop_ready=1. Latched op/addr cleared.
- FSM states: IDLE, REQ, EVAL, WB, RESP.
- IDLE:
  - snoop_ready=1.
  - On snoop_valid at an edge: latch op and addr, go to REQ.
  - snoop_ready=0 in every other state. snoop_valid is ignored there.
- REQ:
  - lkp_req=1 for one cycle.
  - lkp_index and lkp_tag come from the latched addr and are held stable through RESP.
  - Next state: EVAL.
- EVAL: sample lkp_hit, lkp_way and lkp_mesi; a miss is treated as I. Apply the decision table below.
  - upd_en pulses this cycle only if the state changes; upd_way = lkp_way.
  - Next state: WB if the result is HITM, else RESP.
- Decision table (op, state -> result, new state):
  - READ, M -> HITM, S
  - READ, E or S -> HIT, S
  - RWIM, M -> HITM, I
  - RWIM, E or S -> HIT, I
  - INVALIDATE, S -> HIT, I
  - INVALIDATE, E or M -> NOHIT, no update, proto_err pulse
  - WRITE, any state -> NOHIT, no update
  - Any op, I or miss -> NOHIT, no update
  - Undefined op codes -> NOHIT, no update, proto_err pulse
- WB:
  - wb_valid=1 with wb_addr and wb_way held stable until wb_ready.
  - On the edge with wb_valid and wb_ready both high, go to RESP.
  - wb_ready while not in WB is ignored.
- RESP:
  - resp_valid=1 for one cycle; snoop_result is valid this cycle.
  - snoop_result returns to 0 otherwise.
  - Next state: IDLE.
- Latency:
  - Without writeback: accept edge E0, REQ cycle 1, EVAL cycle 2, resp_valid in cycle 3.
  - With HITM: resp_valid in the cycle after the wb handshake.
- Back-to-back snoops: snoop_ready rises in the cycle after RESP. Minimum issue interval is 4 cycles.
- Reset mid-operation: immediate return to IDLE.
  - Any in-flight wb_valid drops.
  - No upd_en or resp_valid is emitted for the aborted snoop.

Optional Feature:
- Macro: SNOOP_STATS_EN.
- When defined:
  - Adds outputs cnt_hit, cnt_hitm and cnt_nohit, each 16 bits.
  - Each counter increments on the resp_valid cycle for its result and saturates at 0xFFFF.
  - Input clr_stats (1 bit) synchronously zeroes all three counters; clr_stats wins over a same-cycle increment.
  - rst zeroes all three counters.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset mid-WB:
  - Stimulus: READ 0x0000_1040, lkp_mesi=M, way 5, wb_ready held low; assert rst for 1 cycle during WB.
  - Required: wb_valid drops asynchronously, snoop_ready=1, no resp_valid.
  - Then: a READ to the same address with lkp_mesi=E -> HIT, upd S, resp_valid in cycle 3.
- READ, modified line:
  - Stimulus: READ 0x1234_5678, lkp_hit=1, way 2, M; wb_ready asserted 2 cycles after wb_valid.
  - Required: upd_en with upd_mesi=S, wb_addr=0x1234_5640, wb_way=2, snoop_result=HITM in the cycle after the handshake.
- RWIM, shared line:
  - Stimulus: RWIM, lkp_mesi=S.
  - Required: HIT, upd_mesi=I, no wb_valid, resp_valid in cycle 3.
- INVALIDATE:
  - Stimulus: INVALIDATE with lkp_mesi=E.
  - Required: proto_err pulse, NOHIT, no upd_en.
  - Stimulus: INVALIDATE with lkp_mesi=S.
  - Required: HIT, upd I.
- WRITE and miss:
  - Stimulus: WRITE with lkp_mesi=M.
  - Required: NOHIT, no upd_en, no wb.
  - Stimulus: READ with lkp_hit=0.
  - Required: NOHIT.
- Stats (with SNOOP_STATS_EN):
  - Stimulus: 3 HIT, 1 HITM and 2 NOHIT snoops.
  - Required: counts read 3/1/2.
  - Stimulus: clr_stats pulse.
  - Required: all three counters 0.
